decoder_2to4: RTL and testbench



---
 rtl/decoder_pkg.sv | 14 +
 rtl/decoder_2to4.sv | 67 ++++++
 tb/tb_decoder_2to4.sv | 133 +++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared constants for one-hot select decoders.
package decoder_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned DEC_W = 4;

    typedef logic [DEC_W-1:0] dec_t;

    localparam dec_t DEC_Y0 = 4'b0001;
    localparam dec_t DEC_Y1 = 4'b0010;
    localparam dec_t DEC_Y2 = 4'b0100;
    localparam dec_t DEC_Y3 = 4'b1000;

endpackage

// File: rtl/decoder_2to4.sv
// Enable-gated 2-to-4 one-hot decoder with optional output register
// and optional output inversion.
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter bit REG_OUT        = 1'b0,
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A0,
    input  logic A1,
    input  logic EN,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3
);

    logic [SEL_W-1:0] w_sel;
    dec_t             w_dec;
    dec_t             w_y;
    dec_t             w_pol;

    assign w_sel = {A1, A0};

    // One-hot decode of the select lines, forced to zero when disabled.
    always_comb begin
        w_dec = '0;
        if (EN) begin
            case (w_sel)
                2'b00:   w_dec = DEC_Y0;
                2'b01:   w_dec = DEC_Y1;
                2'b10:   w_dec = DEC_Y2;
                2'b11:   w_dec = DEC_Y3;
                default: w_dec = 4'b0000;
            endcase
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            dec_t r_q;

            // Output register; synchronous reset wins over any decode.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_dec;
                end
            end

            assign w_y = r_q;
        end else begin : g_comb
            // Clock and reset are intentionally unused in the combinational build.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst_n;

            assign w_y = w_dec;
        end
    endgenerate

    assign w_pol = ACTIVE_LOW_OUT ? '1 : '0;
    assign {Y3, Y2, Y1, Y0} = w_y ^ w_pol;

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench: four decoder builds driven in parallel against a
// behavioural model of the select/enable/reset rules.
module tb_decoder_2to4;

    logic clk;
    logic rst_n;
    logic A0;
    logic A1;
    logic EN;

    logic [3:0] y_comb;
    logic [3:0] y_comb_al;
    logic [3:0] y_reg;
    logic [3:0] y_reg_al;

    int total;
    int bad;

    // Model of the registered stage (pre-inversion) and whether it has seen an edge.
    logic [3:0] q_exp;
    bit         q_valid;

    decoder_2to4 #(.REG_OUT(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .A0(A0), .A1(A1), .EN(EN),
        .Y0(y_comb[0]), .Y1(y_comb[1]), .Y2(y_comb[2]), .Y3(y_comb[3])
    );

    decoder_2to4 #(.REG_OUT(1'b0), .ACTIVE_LOW_OUT(1'b1)) u_comb_al (
        .clk(clk), .rst_n(rst_n), .A0(A0), .A1(A1), .EN(EN),
        .Y0(y_comb_al[0]), .Y1(y_comb_al[1]), .Y2(y_comb_al[2]), .Y3(y_comb_al[3])
    );

    decoder_2to4 #(.REG_OUT(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .A0(A0), .A1(A1), .EN(EN),
        .Y0(y_reg[0]), .Y1(y_reg[1]), .Y2(y_reg[2]), .Y3(y_reg[3])
    );

    decoder_2to4 #(.REG_OUT(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_reg_al (
        .clk(clk), .rst_n(rst_n), .A0(A0), .A1(A1), .EN(EN),
        .Y0(y_reg_al[0]), .Y1(y_reg_al[1]), .Y2(y_reg_al[2]), .Y3(y_reg_al[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: selected line index is 2*A1 + A0; nothing selected when disabled.
    function automatic logic [3:0] model_dec(input logic a1, input logic a0, input logic en);
        int idx;
        idx = 2 * int'(a1) + int'(a0);
        if (!en) return 4'b0000;
        return 4'(1 << idx);
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // builds and that the registered builds still hold the previous value,
    // then check the registered builds after the rising edge.
    task automatic step(input logic rst, input logic en, input logic [1:0] sel);
        logic [3:0] d;
        @(negedge clk);
        rst_n = rst;
        EN    = en;
        A1    = sel[1];
        A0    = sel[0];
        #1;
        d = model_dec(sel[1], sel[0], en);
        check("comb", y_comb, d);
        check("comb_al", y_comb_al, ~d);
        check("onehot", 4'($countones(y_comb) <= 1), 4'd1);
        if (q_valid) begin
            check("reg_hold", y_reg, q_exp);
            check("reg_al_hold", y_reg_al, ~q_exp);
        end
        @(posedge clk);
        q_exp   = rst ? d : 4'b0000;
        q_valid = 1'b1;
        #1;
        check("reg", y_reg, q_exp);
        check("reg_al", y_reg_al, ~q_exp);
        check("reg_onehot", 4'($countones(y_reg) <= 1), 4'd1);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        q_exp   = '0;
        q_valid = 1'b0;
        rst_n   = 1'b0;
        EN      = 1'b0;
        A0      = 1'b0;
        A1      = 1'b0;

        // Reset held for two edges with a live decode request on the inputs.
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b1, 2'b11);
        // First decode at the first edge with reset released.
        step(1'b1, 1'b1, 2'b11);

        // Walk all selects enabled, then disabled.
        for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 2'(s));
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 2'(s));

        // Enable toggle with select held at 2.
        step(1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b1, 2'b10);

        // Mid-operation reset pulse, then resume.
        step(1'b1, 1'b1, 2'b10);
        step(1'b0, 1'b1, 2'b10);
        step(1'b1, 1'b1, 2'b10);

        // Active-low corner: select 1 enabled and disabled.
        step(1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b0, 2'b01);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) != 0), 1'($urandom_range(1)), 2'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
